riscv_lsu: RTL and testbench
============================

# riscv_lsu

Parametrised load/store unit between the core's ALU/register-file datapath and data memory. It replaces the fixed 32-bit, single-cycle, word-only data-memory access with four capabilities:
- sub-word loads and stores with sign/zero extension;
- alignment and encoding checks;
- a request/acknowledge handshake to a memory of arbitrary latency;
- a stall output so a multi-cycle or pipelined core can hold while an access is in flight.

## Interface
Parameters:
- XLEN, 32: data width; legal values 32 or 64.
- ADDR_W, 32: byte-address width.

Ports (clock and reset first):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  core presents an access.
- req_ready  out  1  LSU accepts an access this cycle; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 of the load/store.
- req_addr  in  ADDR_W  byte address from the ALU.
- req_wdata  in  XLEN  store data, rs2.
- rsp_valid  out  1  one-cycle pulse; response fields are valid.
- rsp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- rsp_err  out  2  00 = ok, 01 = misaligned, 10 = illegal funct3.
- stall  out  1  high whenever state is not IDLE.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  word-aligned address; low log2(XLEN/8) bits are 0.
- mem_wdata  out  XLEN  store data shifted into its byte lanes.
- mem_be  out  XLEN/8  byte enables.
- mem_ack  in  1  memory completed the request; mem_rdata is valid this cycle.
- mem_rdata  in  XLEN  full word read from memory.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, decode and latch all req_* fields.
  - Illegal or misaligned → RESP with the error code; no memory access is made.
  - Otherwise → WAIT.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, plus 011 LD and 110 LWU when XLEN = 64.
  - Stores: 000 SB, 001 SH, 010 SW, plus 011 SD when XLEN = 64.
  - Every other encoding gives rsp_err = 10.
- Alignment: halfword requires addr[0] = 0; word requires addr[1:0] = 0; doubleword requires addr[2:0] = 0. A violation gives rsp_err = 01.
- Illegal funct3 takes priority over misalignment.
- WAIT:
  - mem_req = 1, with mem_we, mem_addr, mem_wdata and mem_be held stable from latched values until mem_ack.
  - On mem_ack, capture the extended mem_rdata and go to RESP.
- Store lane placement: replicate rs2's low bytes across lanes; mem_be selects the target lanes.
  - Example: SB to offset 3 gives mem_be = 4'b1000, mem_wdata[31:24] = rs2[7:0].
- Load extraction: shift mem_rdata right by byte offset × 8, then sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU) to XLEN.
- RESP: rsp_valid = 1 for exactly one cycle, then go to IDLE. rsp_rdata and rsp_err hold their values until the next RESP.
- mem_ack outside WAIT is ignored.

## Timing
- Reset values: state = IDLE, req_ready = 1, stall = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 00, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, mem_be = 0.
- Accept at edge N: mem_req is high from cycle N+1.
- Zero-wait memory (mem_ack in the first WAIT cycle): rsp_valid in cycle N+2.
- Each extra wait cycle adds one cycle of latency.
- Error path: rsp_valid in cycle N+1.
- stall is high from N+1 through the rsp_valid cycle inclusive.
- Throughput: no new request is accepted during the RESP cycle, so back-to-back zero-wait accesses complete every 3 cycles.
- Reset asserted mid-access: the next edge returns to IDLE, drops mem_req, and drops any pending response. A stale mem_ack after reset is ignored.
- req_* inputs are sampled only in the accept cycle; later changes have no effect.

## Structure
- Shared package riscv_pkg, holding:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU);
  - the lsu_state_t enum;
  - rsp_err codes (ERR_NONE, ERR_MISALIGN, ERR_ILLEGAL).
- One combinational sub-module, lsu_align: it takes funct3, the address offset, rs2 and mem_rdata, and produces mem_be, shifted wdata, extended rdata and the error code.
- The FSM and registers live in riscv_lsu.

## Test plan
- XLEN = 32, SW 0xDEADBEEF to 0x100, zero-wait memory → mem_be = 1111, mem_addr = 0x100, rsp_valid at N+2, rsp_err = 00.
- LB from 0x103, memory word 0x80FF_1234 → mem_addr = 0x100, rsp_rdata = 0xFFFFFF80. LBU at the same address → rsp_rdata = 0x00000080.
- LH at 0x101 → no mem_req, rsp_valid at N+1, rsp_err = 01. funct3 = 011 with XLEN = 32 → rsp_err = 10.
- SH 0x0000ABCD to 0x102 with mem_ack delayed 4 cycles → mem_be = 1100, mem_wdata[31:16] = 0xABCD, outputs stable for all WAIT cycles, stall high for 6 cycles.
- rst_n low during WAIT, then mem_ack one cycle later → IDLE, mem_req = 0, and no rsp_valid pulse.
- XLEN = 64: LWU from 0x104 with memory word 0x8000_0001_xxxx_xxxx → rsp_rdata = 0x0000_0000_8000_0001. LD from 0x104 → rsp_err = 01.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared load/store definitions: funct3 encodings, LSU FSM states and response error codes.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: funct3 legality, alignment check, store byte-lane placement
// and load extraction with sign/zero extension. Purely combinational, no flow control.
module lsu_align
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int NB = XLEN / 8,
  localparam int OFF_W = $clog2(NB)
) (
  input  logic [2:0]       funct3,
  input  logic             we,
  input  logic [OFF_W-1:0] off,
  input  logic [XLEN-1:0]  wdata,
  input  logic [XLEN-1:0]  rdata,
  output logic [NB-1:0]    be,
  output logic [XLEN-1:0]  wdata_sh,
  output logic [XLEN-1:0]  rdata_ext,
  output logic [1:0]       err
);

  logic             legal;
  logic [OFF_W-1:0] amask;
  logic [NB-1:0]    be_base;
  logic [XLEN-1:0]  sh;

  always_comb begin
    legal = 1'b0;
    if (we)
      legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
              ((XLEN == 64) && (funct3 == F3_D));
    else
      legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
              (funct3 == F3_BU) || (funct3 == F3_HU) ||
              ((XLEN == 64) && ((funct3 == F3_D) || (funct3 == F3_WU)));

    // funct3[1:0] encodes log2 of the access size for every legal encoding
    amask    = '0;
    be_base  = '0;
    wdata_sh = wdata;
    case (funct3[1:0])
      2'd0: begin amask = OFF_W'(3'd0); be_base = NB'(8'h01); wdata_sh = {NB{wdata[7:0]}}; end
      2'd1: begin amask = OFF_W'(3'd1); be_base = NB'(8'h03); wdata_sh = {(NB/2){wdata[15:0]}}; end
      2'd2: begin amask = OFF_W'(3'd3); be_base = NB'(8'h0F); wdata_sh = {(NB/4){wdata[31:0]}}; end
      default: begin amask = OFF_W'(3'd7); be_base = NB'(8'hFF); wdata_sh = wdata; end
    endcase
    be = be_base << off;

    if (!legal)
      err = ERR_ILLEGAL;
    else if ((off & amask) != '0)
      err = ERR_MISALIGN;
    else
      err = ERR_NONE;

    sh = rdata >> {off, 3'b000};
    case (funct3)
      F3_B:    rdata_ext = XLEN'($signed(sh[7:0]));
      F3_H:    rdata_ext = XLEN'($signed(sh[15:0]));
      F3_W:    rdata_ext = XLEN'($signed(sh[31:0]));
      F3_BU:   rdata_ext = XLEN'(sh[7:0]);
      F3_HU:   rdata_ext = XLEN'(sh[15:0]);
      F3_WU:   rdata_ext = XLEN'(sh[31:0]);
      default: rdata_ext = sh;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: accept in IDLE, hold memory request until mem_ack, pulse one response.
// Latency: N+2 for zero-wait memory, N+1 for errors; req_ready only in IDLE, stall otherwise.
module riscv_lsu
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ADDR_W = 32,
  localparam int NB = XLEN / 8,
  localparam int OFF_W = $clog2(NB)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [NB-1:0]     mem_be,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata
);

  lsu_state_t       state;
  logic [2:0]       f3_q;
  logic [OFF_W-1:0] off_q;
  logic             we_q;

  logic [2:0]       a_f3;
  logic             a_we;
  logic [OFF_W-1:0] a_off;
  logic [NB-1:0]    a_be;
  logic [XLEN-1:0]  a_wdata;
  logic [XLEN-1:0]  a_rdata;
  logic [1:0]       a_err;

  // Decode live request fields while idle, latched fields once an access is in flight
  assign a_f3  = (state == IDLE) ? req_funct3 : f3_q;
  assign a_we  = (state == IDLE) ? req_we : we_q;
  assign a_off = (state == IDLE) ? req_addr[OFF_W-1:0] : off_q;

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3    (a_f3),
    .we        (a_we),
    .off       (a_off),
    .wdata     (req_wdata),
    .rdata     (mem_rdata),
    .be        (a_be),
    .wdata_sh  (a_wdata),
    .rdata_ext (a_rdata),
    .err       (a_err)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      f3_q      <= '0;
      off_q     <= '0;
      we_q      <= 1'b0;
      req_ready <= 1'b1;
      stall     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= ERR_NONE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            f3_q      <= req_funct3;
            off_q     <= req_addr[OFF_W-1:0];
            we_q      <= req_we;
            req_ready <= 1'b0;
            stall     <= 1'b1;
            if (a_err != ERR_NONE) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= a_err;
              rsp_rdata <= '0;
            end else begin
              state     <= WAIT;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              mem_wdata <= a_wdata;
              mem_be    <= a_be;
            end
          end
        end
        WAIT: begin
          if (mem_ack) begin
            state     <= RESP;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= ERR_NONE;
            rsp_rdata <= we_q ? '0 : a_rdata;
          end
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          stall     <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: one XLEN=32 and one XLEN=64 instance sharing clock and reset.
module tb_riscv_lsu;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        rv32 = 0, we32 = 0, rr32, rspv32, stall32, mreq32, mwe32, mack32 = 0;
  logic [2:0]  f332 = 0;
  logic [31:0] addr32 = 0, wd32 = 0, rspd32, maddr32, mwd32, mrd32 = 0;
  logic [1:0]  rspe32;
  logic [3:0]  mbe32;

  logic        rv64 = 0, we64 = 0, rr64, rspv64, stall64, mreq64, mwe64, mack64 = 0;
  logic [2:0]  f364 = 0;
  logic [31:0] addr64 = 0, maddr64;
  logic [63:0] wd64 = 0, rspd64, mwd64, mrd64 = 0;
  logic [1:0]  rspe64;
  logic [7:0]  mbe64;

  riscv_lsu #(.XLEN(32), .ADDR_W(32)) u32 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv32), .req_ready(rr32), .req_we(we32),
    .req_funct3(f332), .req_addr(addr32), .req_wdata(wd32), .rsp_valid(rspv32),
    .rsp_rdata(rspd32), .rsp_err(rspe32), .stall(stall32), .mem_req(mreq32),
    .mem_we(mwe32), .mem_addr(maddr32), .mem_wdata(mwd32), .mem_be(mbe32),
    .mem_ack(mack32), .mem_rdata(mrd32)
  );

  riscv_lsu #(.XLEN(64), .ADDR_W(32)) u64 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv64), .req_ready(rr64), .req_we(we64),
    .req_funct3(f364), .req_addr(addr64), .req_wdata(wd64), .rsp_valid(rspv64),
    .rsp_rdata(rspd64), .rsp_err(rspe64), .stall(stall64), .mem_req(mreq64),
    .mem_we(mwe64), .mem_addr(maddr64), .mem_wdata(mwd64), .mem_be(mbe64),
    .mem_ack(mack64), .mem_rdata(mrd64)
  );

  // Request is accepted at the posedge following the call; returns just after that edge
  task automatic issue32(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    rv32 = 1; we32 = we; f332 = f3; addr32 = a; wd32 = d;
    @(posedge clk);
    #1 rv32 = 0;
  endtask

  task automatic issue64(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [63:0] d);
    @(negedge clk);
    rv64 = 1; we64 = we; f364 = f3; addr64 = a; wd64 = d;
    @(posedge clk);
    #1 rv64 = 0;
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (rr32 !== 1'b1) begin errors++; $display("FAIL rst_req_ready got=%b exp=1", rr32); end
    checks++; if ({stall32, rspv32, mreq32, mwe32} !== 4'b0000) begin errors++; $display("FAIL rst_ctrl got=%b exp=0000", {stall32, rspv32, mreq32, mwe32}); end
    checks++; if ({rspd32, rspe32, maddr32, mwd32, mbe32} !== '0) begin errors++; $display("FAIL rst_data32 got=%h/%h/%h/%h/%h exp=0", rspd32, rspe32, maddr32, mwd32, mbe32); end
    checks++; if ({rr64, stall64, rspv64, mreq64, mwe64} !== 5'b10000) begin errors++; $display("FAIL rst_ctrl64 got=%b exp=10000", {rr64, stall64, rspv64, mreq64, mwe64}); end
    checks++; if ({rspd64, rspe64, maddr64, mwd64, mbe64} !== '0) begin errors++; $display("FAIL rst_data64 got=%h/%h/%h/%h/%h exp=0", rspd64, rspe64, maddr64, mwd64, mbe64); end
    rst_n = 1;
  endtask

  task automatic test_store_word;
    issue32(1, F3_W, 32'h100, 32'hDEADBEEF);
    @(negedge clk);
    checks++; if ({mreq32, mwe32, stall32, rspv32, rr32} !== 5'b11100) begin errors++; $display("FAIL sw_ctrl got=%b exp=11100", {mreq32, mwe32, stall32, rspv32, rr32}); end
    checks++; if (mbe32 !== 4'b1111) begin errors++; $display("FAIL sw_be got=%b exp=1111", mbe32); end
    checks++; if (maddr32 !== 32'h100) begin errors++; $display("FAIL sw_addr got=%h exp=00000100", maddr32); end
    checks++; if (mwd32 !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata got=%h exp=deadbeef", mwd32); end
    mack32 = 1;
    @(negedge clk);
    mack32 = 0;
    checks++; if ({rspv32, mreq32, stall32} !== 3'b101) begin errors++; $display("FAIL sw_rsp_ctrl got=%b exp=101", {rspv32, mreq32, stall32}); end
    checks++; if ({rspe32, rspd32} !== {2'b00, 32'h0}) begin errors++; $display("FAIL sw_rsp got=%b/%h exp=00/0", rspe32, rspd32); end
    @(negedge clk);
    checks++; if ({rspv32, stall32, rr32} !== 3'b001) begin errors++; $display("FAIL sw_idle got=%b exp=001", {rspv32, stall32, rr32}); end
    issue32(1, F3_B, 32'h103, 32'h1234565A);
    @(negedge clk);
    checks++; if (mbe32 !== 4'b1000) begin errors++; $display("FAIL sb_be got=%b exp=1000", mbe32); end
    checks++; if (mwd32[31:24] !== 8'h5A) begin errors++; $display("FAIL sb_lane got=%h exp=5a", mwd32[31:24]); end
    mack32 = 1;
    @(negedge clk);
    mack32 = 0;
  endtask

  task automatic test_load_byte;
    logic [2:0] f3s [2];
    logic [31:0] exps [2];
    f3s[0] = F3_B;  exps[0] = 32'hFFFFFF80;
    f3s[1] = F3_BU; exps[1] = 32'h00000080;
    for (int i = 0; i < 2; i++) begin
      issue32(0, f3s[i], 32'h103, 32'h0);
      @(negedge clk);
      checks++; if ({maddr32, mwe32} !== {32'h100, 1'b0}) begin errors++; $display("FAIL lb%0d_addr got=%h/%b exp=00000100/0", i, maddr32, mwe32); end
      mack32 = 1; mrd32 = 32'h80FF1234;
      @(negedge clk);
      mack32 = 0;
      checks++; if ({rspv32, rspe32} !== 3'b100) begin errors++; $display("FAIL lb%0d_rsp got=%b exp=100", i, {rspv32, rspe32}); end
      checks++; if (rspd32 !== exps[i]) begin errors++; $display("FAIL lb%0d_data got=%h exp=%h", i, rspd32, exps[i]); end
    end
  endtask

  task automatic test_errors;
    logic        wes [4];
    logic [2:0]  f3s [4];
    logic [31:0] ads [4];
    logic [1:0]  exps [4];
    wes[0] = 0; f3s[0] = F3_H;   ads[0] = 32'h101; exps[0] = ERR_MISALIGN;
    wes[1] = 0; f3s[1] = F3_D;   ads[1] = 32'h100; exps[1] = ERR_ILLEGAL;
    wes[2] = 1; f3s[2] = 3'b111; ads[2] = 32'h101; exps[2] = ERR_ILLEGAL;
    wes[3] = 0; f3s[3] = F3_W;   ads[3] = 32'h102; exps[3] = ERR_MISALIGN;
    for (int i = 0; i < 4; i++) begin
      issue32(wes[i], f3s[i], ads[i], 32'hFFFFFFFF);
      @(negedge clk);
      checks++; if ({rspv32, mreq32, stall32} !== 3'b101) begin errors++; $display("FAIL err%0d_ctrl got=%b exp=101", i, {rspv32, mreq32, stall32}); end
      checks++; if ({rspe32, rspd32} !== {exps[i], 32'h0}) begin errors++; $display("FAIL err%0d_code got=%b/%h exp=%b/0", i, rspe32, rspd32, exps[i]); end
      @(negedge clk);
      checks++; if ({rspv32, stall32, rspe32} !== {2'b00, exps[i]}) begin errors++; $display("FAIL err%0d_hold got=%b exp=00%b", i, {rspv32, stall32, rspe32}, exps[i]); end
    end
  endtask

  task automatic test_store_half_delayed;
    int stall_cycles = 0;
    issue32(1, F3_H, 32'h102, 32'h0000ABCD);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) begin addr32 = 32'h777; wd32 = 32'h11111111; f332 = F3_B; end
      if (stall32) stall_cycles++;
      if (k <= 5) begin
        checks++; if ({mreq32, mwe32, mbe32, maddr32} !== {2'b11, 4'b1100, 32'h100}) begin errors++; $display("FAIL sh_wait%0d got=%b%b/%b/%h exp=11/1100/00000100", k, mreq32, mwe32, mbe32, maddr32); end
        checks++; if (mwd32[31:16] !== 16'hABCD) begin errors++; $display("FAIL sh_wdata%0d got=%h exp=abcd", k, mwd32[31:16]); end
      end
      if (k == 6) begin
        checks++; if ({rspv32, rspe32} !== 3'b100) begin errors++; $display("FAIL sh_rsp got=%b exp=100", {rspv32, rspe32}); end
      end
      mack32 = (k == 5);
    end
    checks++; if (stall_cycles != 6) begin errors++; $display("FAIL sh_stall_cycles got=%0d exp=6", stall_cycles); end
  endtask

  task automatic test_back_to_back;
    logic [9:0] seen = '0;
    @(negedge clk);
    rv32 = 1; we32 = 0; f332 = F3_W; addr32 = 32'h200; mack32 = 1; mrd32 = 32'h12345678;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      seen[k] = rspv32;
    end
    rv32 = 0; mack32 = 0;
    checks++; if (seen !== 10'h124) begin errors++; $display("FAIL b2b_pulses got=%b exp=0100100100", seen); end
    checks++; if (rspd32 !== 32'h12345678) begin errors++; $display("FAIL b2b_data got=%h exp=12345678", rspd32); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int pulses = 0;
    issue32(0, F3_W, 32'h300, 32'h0);
    @(negedge clk);
    checks++; if (mreq32 !== 1'b1) begin errors++; $display("FAIL rmid_req got=%b exp=1", mreq32); end
    rst_n = 0;
    @(negedge clk);
    rst_n = 1; mack32 = 1;
    checks++; if ({mreq32, stall32, rr32} !== 3'b001) begin errors++; $display("FAIL rmid_idle got=%b exp=001", {mreq32, stall32, rr32}); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      mack32 = 0;
      if (rspv32 || mreq32) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL rmid_stale got=%0d exp=0", pulses); end
  endtask

  task automatic test_xlen64;
    logic [2:0]  f3s [2];
    logic [63:0] exps [2];
    f3s[0] = F3_WU; exps[0] = 64'h0000000080000001;
    f3s[1] = F3_W;  exps[1] = 64'hFFFFFFFF80000001;
    for (int i = 0; i < 2; i++) begin
      issue64(0, f3s[i], 32'h104, 64'h0);
      @(negedge clk);
      checks++; if ({mreq64, mbe64, maddr64} !== {1'b1, 8'hF0, 32'h100}) begin errors++; $display("FAIL x64_%0d_req got=%b/%b/%h exp=1/11110000/00000100", i, mreq64, mbe64, maddr64); end
      mack64 = 1; mrd64 = 64'h80000001_12345678;
      @(negedge clk);
      mack64 = 0;
      checks++; if ({rspv64, rspe64, rspd64} !== {3'b100, exps[i]}) begin errors++; $display("FAIL x64_%0d_rsp got=%b%b/%h exp=100/%h", i, rspv64, rspe64, rspd64, exps[i]); end
    end
    issue64(0, F3_D, 32'h104, 64'h0);
    @(negedge clk);
    checks++; if ({rspv64, mreq64, rspe64} !== 4'b1001) begin errors++; $display("FAIL x64_ld_mis got=%b exp=1001", {rspv64, mreq64, rspe64}); end
    issue64(1, F3_D, 32'h108, 64'h1122334455667788);
    @(negedge clk);
    checks++; if ({mbe64, maddr64, mwd64} !== {8'hFF, 32'h108, 64'h1122334455667788}) begin errors++; $display("FAIL x64_sd got=%b/%h/%h exp=11111111/00000108/1122334455667788", mbe64, maddr64, mwd64); end
    mack64 = 1;
    @(negedge clk);
    mack64 = 0;
    checks++; if ({rspv64, rspe64, rspd64} !== {3'b100, 64'h0}) begin errors++; $display("FAIL x64_sd_rsp got=%b%b/%h exp=100/0", rspv64, rspe64, rspd64); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_store_word();
    test_load_byte();
    test_errors();
    test_store_half_delayed();
    test_back_to_back();
    test_reset_mid();
    test_xlen64();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
